// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default
// constants and the IF/ID payload layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'hE1A0_0000;
    localparam logic [31:0] PC_STEP_DEF   = 32'd4;
    localparam int          IFID_W        = 65;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    function automatic ifid_t make_bubble(input logic [31:0] nop);
        ifid_t b;
        b.valid = 1'b0;
        b.pc    = 32'd0;
        b.instr = nop;
        return b;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Request/ready bus between the fetch stage (master) and instruction memory (slave).
interface if_fetch_stage_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register with load/hold/bubble controls; bubble beats hold,
// and reset loads the bubble value.
module if_id_reg #(
    parameter int             W          = 65,
    parameter logic [W-1:0]   BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (bubble) begin
            q_d = BUBBLE_VAL;
        end else if (load && !hold) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= BUBBLE_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency
// memory, and feeds the IF/ID register with freeze and branch-redirect support.
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = PC_STEP_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze,
    input  logic                     Branch_taken,
    input  logic [31:0]              Branch_Address,
    if_fetch_stage_if.master         mem,
    output logic [31:0]              Instruction_out,
    output logic [31:0]              PC_out,
    output logic                     valid_out
);

    localparam ifid_t BUBBLE = make_bubble(NOP_INSTR);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  saved_addr_q, saved_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;

    logic [31:0]  pc_plus;
    logic         ifid_load;
    logic         ifid_bubble;
    ifid_t        ifid_in;
    ifid_t        ifid_q;

    assign pc_plus = pc_q + PC_STEP;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        saved_addr_d = saved_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        mem.mem_req  = 1'b0;
        mem.mem_addr = pc_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_in      = '{valid: 1'b1, pc: pc_plus, instr: mem.mem_rdata};

        case (state_q)
            ST_REQ: begin
                mem.mem_req = 1'b1;
                if (Branch_taken) begin
                    pc_d        = Branch_Address;
                    ifid_bubble = 1'b1;
                    if (!mem.mem_ready) begin
                        // The outstanding request must complete at its original address.
                        saved_addr_d = pc_q;
                        state_d      = ST_DISCARD;
                    end
                end else if (mem.mem_ready) begin
                    pc_d = pc_plus;
                    if (!freeze) begin
                        ifid_load = 1'b1;
                    end else begin
                        buf_instr_d = mem.mem_rdata;
                        buf_pc_d    = pc_plus;
                        state_d     = ST_HOLD;
                    end
                end else if (!freeze) begin
                    ifid_bubble = 1'b1;
                end
            end

            ST_HOLD: begin
                ifid_in = '{valid: 1'b1, pc: buf_pc_q, instr: buf_instr_q};
                if (Branch_taken) begin
                    pc_d        = Branch_Address;
                    ifid_bubble = 1'b1;
                    state_d     = ST_REQ;
                end else if (!freeze) begin
                    ifid_load = 1'b1;
                    state_d   = ST_REQ;
                end
            end

            ST_DISCARD: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = saved_addr_q;
                if (Branch_taken) begin
                    pc_d = Branch_Address;
                end
                if (mem.mem_ready) begin
                    state_d = ST_REQ;
                end
                if (Branch_taken || !freeze) begin
                    ifid_bubble = 1'b1;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            saved_addr_q <= 32'd0;
            buf_instr_q  <= 32'd0;
            buf_pc_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            saved_addr_q <= saved_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

    if_id_reg #(
        .W          (IFID_W),
        .BUBBLE_VAL (BUBBLE)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .hold   (freeze),
        .bubble (ifid_bubble),
        .d      (ifid_in),
        .q      (ifid_q)
    );

    assign Instruction_out = ifid_q.instr;
    assign PC_out          = ifid_q.pc;
    assign valid_out       = ifid_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns addr ^ 32'hA5A5_0000.
module tb_if_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'd0;
    logic        ready = 1'b0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_stage_if bus ();
    assign bus.mem_ready = ready;
    assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .Branch_taken   (branch_taken),
        .Branch_Address (branch_address),
        .mem            (bus.master),
        .Instruction_out(instruction_out),
        .PC_out         (pc_out),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("check %s ok (%h)", tag, got);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc, input logic v);
        chk({tag, ".instr"}, instruction_out, ins);
        chk({tag, ".pc"}, pc_out, pc);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".instr"}, instruction_out, NOP);
        chk({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_ifid("reset", NOP, 32'd0, 1'b0);
        chk("reset.req", {31'd0, bus.mem_req}, 32'd1);
        chk("reset.addr", bus.mem_addr, 32'd0);
        rst = 1'b0;

        // Zero-wait streaming from 0
        ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("stream.addr", bus.mem_addr, 32'(4 * i));
            step();
            chk_ifid("stream", word(32'(4 * i)), 32'(4 * i + 4), 1'b1);
        end

        // Three wait states at address 8
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait.req", {31'd0, bus.mem_req}, 32'd1);
            chk("wait.addr", bus.mem_addr, 32'h8);
            chk_bubble("wait");
        end
        ready = 1'b1;
        step();
        chk_ifid("wait.done", word(32'h8), 32'hC, 1'b1);
        step();
        chk_ifid("fetch_c", word(32'hC), 32'h10, 1'b1);

        // Freeze while word@0x10 returns
        freeze = 1'b1;
        step();
        ready = 1'b0;
        chk_ifid("frz1", word(32'hC), 32'h10, 1'b1);
        chk("frz1.req", {31'd0, bus.mem_req}, 32'd0);
        step();
        chk_ifid("frz2", word(32'hC), 32'h10, 1'b1);
        chk("frz2.req", {31'd0, bus.mem_req}, 32'd0);
        freeze = 1'b0;
        step();
        chk_ifid("unfrz", word(32'h10), 32'h14, 1'b1);
        chk("unfrz.addr", bus.mem_addr, 32'h14);

        // Branch while request @0x20 is stalled
        ready = 1'b1;
        step();
        step();
        step();
        ready = 1'b0;
        step();
        chk("br.stall.addr", bus.mem_addr, 32'h20);
        branch_taken = 1'b1;
        branch_address = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("br.disc.addr", bus.mem_addr, 32'h20);
        chk("br.disc.req", {31'd0, bus.mem_req}, 32'd1);
        chk_bubble("br.disc");
        step();
        chk("br.disc2.addr", bus.mem_addr, 32'h20);
        chk_bubble("br.disc2");
        ready = 1'b1;
        step();
        chk_bubble("br.drop");
        chk("br.target.addr", bus.mem_addr, 32'h100);
        step();
        chk_ifid("br.target", word(32'h100), 32'h104, 1'b1);

        // Branch coincident with freeze while holding a buffered word
        freeze = 1'b1;
        step();
        ready = 1'b0;
        chk("hold.req", {31'd0, bus.mem_req}, 32'd0);
        branch_taken = 1'b1;
        branch_address = 32'h200;
        step();
        branch_taken = 1'b0;
        freeze = 1'b0;
        chk_bubble("hold.br");
        chk("hold.br.addr", bus.mem_addr, 32'h200);
        chk("hold.br.req", {31'd0, bus.mem_req}, 32'd1);

        // PC wrap at 0xFFFF_FFFC (branch coincident with ready drops the data)
        ready = 1'b1;
        branch_taken = 1'b1;
        branch_address = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk_bubble("wrap.br");
        chk("wrap.addr", bus.mem_addr, 32'hFFFF_FFFC);
        step();
        chk_ifid("wrap", 32'h5A5A_FFFC, 32'h0, 1'b1);
        chk("wrap.next", bus.mem_addr, 32'h0);

        // Reset in the middle of DISCARD
        step();
        chk("pre.addr", bus.mem_addr, 32'h4);
        ready = 1'b0;
        branch_taken = 1'b1;
        branch_address = 32'h300;
        step();
        branch_taken = 1'b0;
        chk("rdisc.addr", bus.mem_addr, 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2.addr", bus.mem_addr, 32'h0);
        chk("rst2.req", {31'd0, bus.mem_req}, 32'd1);
        chk_ifid("rst2", NOP, 32'd0, 1'b0);
        ready = 1'b1;
        step();
        chk_ifid("rst2.fetch", word(32'h0), 32'h4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and runs a req/ready handshake to a variable-latency instruction memory.
- Drives the IF/ID pipeline register (Instruction_out, PC_out) that decode consumes every cycle.
- Honours the hazard freeze from decode and the branch redirect from execute. Buffers one returned word when a fetch completes during a freeze.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential fetches.
- NOP_INSTR, 32'hE1A0_0000, bubble instruction (MOV r0,r0) placed in Instruction_out on flush or stall.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- freeze  input  1  hazard stall from decode; hold the IF/ID register and do not launch new fetches.
- Branch_taken  input  1  redirect from execute; has priority over freeze.
- Branch_Address  input  32  redirect target PC.
- mem_req  output  1  fetch request; once high, held with stable mem_addr until mem_ready.
- mem_addr  output  32  fetch address.
- mem_ready  input  1  memory accepts the request; mem_rdata valid in the same cycle.
- mem_rdata  input  32  fetched instruction word.
- Instruction_out  output  32  IF/ID instruction to decode.
- PC_out  output  32  IF/ID value = fetched address + PC_STEP.
- valid_out  output  1  IF/ID slot holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=1 at a clk edge):
  - PC=RESET_PC, state=REQ.
  - Instruction_out=NOP_INSTR, PC_out=0, valid_out=0.
  - Hold buffer cleared.
  - Reset mid-transaction abandons the outstanding request; memory must tolerate this.
- State REQ: mem_req=1, mem_addr=PC. Priority order:
  - Branch_taken & mem_ready: drop data; PC<=Branch_Address; IF/ID<=bubble; stay REQ.
  - Branch_taken & !mem_ready: PC<=Branch_Address; saved_addr<=old PC; IF/ID<=bubble; go DISCARD.
  - mem_ready & !freeze: IF/ID<={mem_rdata, PC+PC_STEP, valid=1}; PC<=PC+PC_STEP; stay REQ. Sustains 1 instruction/cycle.
  - mem_ready & freeze: buffer<={mem_rdata, PC+PC_STEP}; PC<=PC+PC_STEP; IF/ID held; go HOLD.
  - !mem_ready: IF/ID held if freeze, else IF/ID<=bubble; stay REQ.
- State HOLD: mem_req=0.
  - Branch_taken: discard buffer; PC<=Branch_Address; IF/ID<=bubble; go REQ.
  - freeze: hold everything.
  - !freeze: IF/ID<=buffer with valid=1; go REQ.
- State DISCARD: mem_req=1, mem_addr=saved_addr (address must not change while the request is outstanding).
  - mem_ready: data dropped; go REQ, which fetches the current PC.
  - Branch_taken: PC<=new target. Coincident with mem_ready, still go REQ.
  - IF/ID: bubble unless freeze, in which case held. Branch_taken always forces a bubble.
- Freeze rules:
  - Freeze never deasserts mem_req once it is asserted.
  - Freeze in REQ with no response pending keeps mem_req high; this is legal because the buffer absorbs the response.
- Arithmetic: PC+PC_STEP is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). No alignment check; low 2 bits pass through.
- Latency:
  - Zero-wait memory: word fetched at an edge appears on Instruction_out one cycle later.
  - Branch: first target instruction reaches IF/ID no earlier than 2 cycles after Branch_taken is sampled.

Decomposition:
- Shared package (fetch_pkg):
  - State encoding: REQ=2'd0, HOLD=2'd1, DISCARD=2'd2.
  - NOP_INSTR default.
  - PC_STEP default.
- One sub-module, if_id_reg:
  - 65-bit register {valid, PC, Instruction} with sync reset, load, hold and bubble controls.
  - Bubble overrides hold.
  - Instantiated once here; reusable for later pipeline registers.

Test Plan:
- Reset, then mem_ready=1 every cycle with mem_rdata=addr^32'hA5A5_0000 -> mem_addr 0,4,8,... and Instruction_out/PC_out stream one per cycle (PC_out 4,8,12), valid_out=1.
- mem_ready low for 3 cycles at addr 8 -> mem_req high and mem_addr=8 throughout; three bubbles (NOP_INSTR, valid_out=0); then word@8 with PC_out=12.
- freeze=1 two cycles while word@0x10 returns -> IF/ID held; no new mem_req after acceptance; after freeze drops, word@0x10 and PC_out 0x14 appear next cycle.
- Branch_taken to 0x100 while request @0x20 stalled -> mem_addr stays 0x20 until ready; data dropped; next request at 0x100; IF/ID bubbles until word@0x100.
- Branch_taken coincident with freeze in HOLD -> buffer dropped; bubble; next mem_addr=Branch_Address.
- PC=0xFFFF_FFFC fetch -> PC_out=0, next mem_addr=0; rst asserted mid-DISCARD -> next cycle state REQ, mem_addr=RESET_PC, valid_out=0.
